// File: rtl/hazard3_tick_gen_pkg.sv
// Shared register map and field layout for the hazard3 machine-timer tick prescaler.
package hazard3_tick_gen_pkg;

   localparam logic [15:0] ADDR_CTRL  = 16'h0000;
   localparam logic [15:0] ADDR_DIV   = 16'h0004;
   localparam logic [15:0] ADDR_COUNT = 16'h0008;

   localparam int unsigned DIV_FRAC_LSB = 0;
   localparam int unsigned DIV_INT_LSB  = 8;
   localparam int unsigned W_DIV_FRAC   = 8;

endpackage

// File: rtl/hazard3_tick_gen_frac.sv
// Fractional-divide accumulator: adds the fraction on each advance and reports the carry
// that stretches the following period by one cycle.
module hazard3_tick_gen_frac
   import hazard3_tick_gen_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  adv,
   input  logic [W_DIV_FRAC-1:0] frac,
   output logic                  carry
);

   logic [W_DIV_FRAC-1:0] acc;
   logic [W_DIV_FRAC:0]   sum;

   always_comb begin
      sum = {1'b0, acc} + {1'b0, frac};
   end

   assign carry = sum[W_DIV_FRAC];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (adv) begin
         acc <= sum[W_DIV_FRAC-1:0];
      end
   end

endmodule

// File: rtl/hazard3_tick_gen.sv
// Programmable tick prescaler for the RISC-V machine timer, APB-programmed.
// Define HAZARD3_TICK_GEN_FRAC_EN to build the fractional divider.
module hazard3_tick_gen
   import hazard3_tick_gen_pkg::*;
#(
   parameter int unsigned W_DIV_INT     = 16,
   parameter int unsigned DIV_INT_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        tick
);

   // One extra bit: a carry-extended period can reach 2**W_DIV_INT.
   localparam int unsigned W_CNT = W_DIV_INT + 1;

   logic                  en;
   logic [W_DIV_INT-1:0]  div_int;
   logic [W_DIV_FRAC-1:0] div_frac;
   logic [W_CNT-1:0]      count;
   logic                  wr;
   logic                  wr_ctrl;
   logic                  wr_div;
   logic                  start;
   logic                  stop;
   logic                  fire;
   logic                  carry;
   logic                  acc_clr;
   logic [W_DIV_INT-1:0]  int_eff;
   logic [W_CNT-1:0]      reload;
   logic                  unused_bits;

   assign pready  = 1'b1;
   assign pslverr = 1'b0;

   assign wr      = psel & penable & pwrite;
   assign wr_ctrl = wr && (paddr[15:0] == ADDR_CTRL);
   assign wr_div  = wr && (paddr[15:0] == ADDR_DIV);
   assign start   = wr_ctrl & pwdata[0] & ~en;
   assign stop    = wr_ctrl & ~pwdata[0] & en;
   assign fire    = en & ~stop & (count == W_CNT'(1));
   assign int_eff = (div_int == '0) ? W_DIV_INT'(1) : div_int;
   assign reload  = {1'b0, int_eff} + W_CNT'(carry);
   assign acc_clr = ~en | stop;

   assign unused_bits = ^{paddr[31:16], pwdata};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en      <= 1'b0;
         div_int <= W_DIV_INT'(DIV_INT_RESET);
      end else begin
         if (wr_ctrl) en      <= pwdata[0];
         if (wr_div)  div_int <= pwdata[DIV_INT_LSB +: W_DIV_INT];
      end
   end

`ifdef HAZARD3_TICK_GEN_FRAC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_frac <= '0;
      end else if (wr_div) begin
         div_frac <= pwdata[DIV_FRAC_LSB +: W_DIV_FRAC];
      end
   end

   hazard3_tick_gen_frac u_frac (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .adv   (fire),
      .frac  (div_frac),
      .carry (carry)
   );
`else
   assign div_frac = '0;
   assign carry    = 1'b0;
`endif

   // Reload happens on the tick edge itself, so DIV writes landing on that edge miss it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (start) begin
         count <= {1'b0, int_eff};
         tick  <= 1'b0;
      end else if (!en || stop) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (fire) begin
         count <= reload;
         tick  <= 1'b1;
      end else begin
         count <= count - W_CNT'(1);
         tick  <= 1'b0;
      end
   end

   always_comb begin
      prdata = '0;
      case (paddr[15:0])
         ADDR_CTRL:  prdata[1:0] = {en, en};
         ADDR_DIV: begin
            prdata[DIV_INT_LSB  +: W_DIV_INT]  = div_int;
            prdata[DIV_FRAC_LSB +: W_DIV_FRAC] = div_frac;
         end
         ADDR_COUNT: prdata[W_CNT-1:0] = count;
         default:    prdata = '0;
      endcase
   end

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Bench for hazard3_tick_gen: tick-time reference model plus directed period checks.
`timescale 1ns/1ps
module tb_hazard3_tick_gen;

   localparam int unsigned W    = 16;
   localparam int unsigned DRST = 1;
`ifdef HAZARD3_TICK_GEN_FRAC_EN
   localparam bit FRAC = 1'b1;
`else
   localparam bit FRAC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr, tick;

   hazard3_tick_gen #(.W_DIV_INT(W), .DIV_INT_RESET(DRST)) dut (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .tick(tick)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;
   int unsigned edge_n = 0;
   int unsigned ticks_q[$];

   // Bus values as seen by the most recent rising edge.
   logic        s_rst = 1'b1, s_wr = 1'b0;
   logic [31:0] s_addr = '0, s_data = '0;

   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      s_rst  <= rst;
      s_wr   <= psel & penable & pwrite;
      s_addr <= paddr;
      s_data <= pwdata;
   end

   // Model: absolute edge number of the next tick, plus the accumulator as an integer.
   bit          m_en, m_tick;
   int unsigned m_int, m_frac, m_acc, m_next;

   function automatic int unsigned eff(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (a[15:0])
         16'h0000: return {30'd0, m_en, m_en};
         16'h0004: return (m_int << 8) | m_frac;
         16'h0008: return m_en ? (m_next - edge_n) : 32'd0;
         default:  return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_tick = 0; m_int = DRST; m_frac = 0; m_acc = 0; m_next = 0;
   endtask

   task automatic model_step();
      bit wc, wd;
      int unsigned sum;
      wc = s_wr && (s_addr[15:0] == 16'h0000);
      wd = s_wr && (s_addr[15:0] == 16'h0004);
      m_tick = 0;
      if (m_en) begin
         if (wc && !s_data[0]) begin
            m_en = 0; m_acc = 0;
         end else if (edge_n == m_next) begin
            m_tick = 1;
            sum    = m_acc + m_frac;
            m_next = edge_n + eff(m_int) + sum / 256;
            m_acc  = sum % 256;
         end
      end else if (wc && s_data[0]) begin
         m_en = 1; m_acc = 0; m_next = edge_n + eff(m_int);
      end
      if (wd) begin
         m_int  = (s_data >> 8) & ((32'd1 << W) - 1);
         m_frac = FRAC ? (s_data & 32'hFF) : 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   task automatic on_negedge();
      if (rst || s_rst) model_reset();
      else              model_step();
      if (tick) ticks_q.push_back(edge_n);
      if (chk_on) begin
         chk("tick", {31'd0, tick}, {31'd0, m_tick});
         chk("prdata", prdata, m_read(paddr));
         chk("pready", {31'd0, pready}, 32'd1);
         chk("pslverr", {31'd0, pslverr}, 32'd0);
      end
   endtask

   always @(negedge clk) on_negedge();

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int unsigned wedge);
      psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
      cyc(1);
      penable = 1;
      cyc(1);
      wedge = edge_n;
      psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1; penable = 0; pwrite = 0; paddr = a;
      #1;
      d = prdata;
      psel = 0;
   endtask

   task automatic check_periods(input string nm, input int unsigned base, input int unsigned p[$]);
      int unsigned budget, prev;
      int k;
      budget = 20;
      foreach (p[i]) budget += p[i];
      k = 0;
      while (ticks_q.size() < p.size() && k < budget) begin
         cyc(1);
         k++;
      end
      if (ticks_q.size() < p.size()) begin
         chk({nm, "_timeout"}, ticks_q.size(), p.size());
      end else begin
         prev = base;
         foreach (p[i]) begin
            chk(nm, ticks_q[i] - prev, p[i]);
            prev = ticks_q[i];
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e, t;
      int unsigned pq[$];
      logic [31:0] rd;
      int hi;

      model_reset();
      cyc(3);
      chk_on = 1;
      rst = 0;
      cyc(1);

      // Reset defaults
      chk("rst_tick", {31'd0, tick}, 32'd0);
      apb_read(32'h0, rd);  chk("rst_ctrl", rd, 32'h0);
      apb_read(32'h4, rd);  chk("rst_div", rd, 32'h100);
      apb_read(32'h8, rd);  chk("rst_count", rd, 32'h0);
      ticks_q.delete();
      cyc(100);
      chk("rst_idle_ticks", ticks_q.size(), 0);

      // Integer divide by 4
      apb_write(32'h4, 32'h400, e);
      apb_write(32'h0, 32'h1, e);
      ticks_q.delete();
      pq = {};
      for (int i = 0; i < 20; i++) pq.push_back(4);
      check_periods("int4_period", e, pq);
      apb_write(32'h0, 32'h0, e);

      // Fractional divide 3.5
      apb_write(32'h4, 32'h380, e);
      apb_read(32'h4, rd);
      chk("frac_div_rb", rd, FRAC ? 32'h380 : 32'h300);
      apb_write(32'h0, 32'h1, e);
      ticks_q.delete();
      if (FRAC) pq = {3, 3, 4, 3, 4, 3, 4};
      else      pq = {3, 3, 3, 3, 3, 3, 3};
      check_periods("frac_period", e, pq);
      apb_write(32'h0, 32'h0, e);

      // Mid-period reprogram 10 -> 2
      apb_write(32'h4, 32'hA00, e);
      apb_write(32'h0, 32'h1, e);
      ticks_q.delete();
      check_periods("reprog_first", e, {10});
      t = ticks_q.pop_front();
      apb_write(32'h4, 32'h200, e);
      chk("reprog_wr_phase", e - t, 3);
      check_periods("reprog_period", t, {10, 2, 2, 2});
      apb_write(32'h0, 32'h0, e);

      // Degenerate divisors keep tick high
      for (int d = 0; d < 2; d++) begin
         apb_write(32'h4, (d == 0) ? 32'h0 : 32'h100, e);
         apb_write(32'h0, 32'h1, e);
         cyc(1);
         hi = 0;
         for (int i = 0; i < 20; i++) begin
            if (tick) hi++;
            cyc(1);
         end
         chk("degenerate_high", hi, 20);
         apb_write(32'h0, 32'h0, e);
      end

      // Disable, re-enable, reset
      apb_write(32'h4, 32'h800, e);
      apb_write(32'h0, 32'h1, e);
      ticks_q.delete();
      check_periods("dis_first", e, {8});
      t = ticks_q.pop_front();
      cyc(2);
      apb_write(32'h0, 32'h0, e);
      chk("dis_phase", e - t, 5);
      chk("dis_tick", {31'd0, tick}, 32'd0);
      apb_read(32'h8, rd);  chk("dis_count", rd, 32'h0);
      apb_write(32'h0, 32'h1, e);
      ticks_q.delete();
      check_periods("reen_first", e, {8});
      t = ticks_q.pop_front();
      cyc(2);
      chk("rst_phase", edge_n - t, 3);
      rst = 1;
      #1;
      chk("rst_mid_tick", {31'd0, tick}, 32'd0);
      apb_read(32'h0, rd);  chk("rst_mid_ctrl", rd, 32'h0);
      cyc(2);
      rst = 0;
      ticks_q.delete();
      cyc(30);
      chk("post_rst_ticks", ticks_q.size(), 0);

      // Async reset while tick is held high
      apb_write(32'h4, 32'h0, e);
      apb_write(32'h0, 32'h1, e);
      cyc(3);
      chk("hold_tick_high", {31'd0, tick}, 32'd1);
      #2;
      rst = 1;
      #1;
      chk("async_rst_tick", {31'd0, tick}, 32'd0);
      cyc(2);
      rst = 0;
      cyc(2);

      // Randomized bus traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         logic [31:0] d;
         r = $urandom_range(0, 7);
         case (r)
            0: paddr = 32'h0000_0000;
            1: paddr = 32'h0000_0004;
            2: paddr = 32'h0000_0008;
            3: paddr = 32'h0000_000C;
            4: paddr = 32'h0001_0004;
            5: paddr = 32'hFFFF_0000;
            6: paddr = 32'h0000_0004;
            default: paddr = $urandom;
         endcase
         d = $urandom;
         d[15:8] = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 7) != 0) d[31:16] = '0;
         d[0] = ($urandom_range(0, 3) != 0);
         pwdata  = d;
         psel    = 1'($urandom);
         penable = 1'($urandom);
         pwrite  = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      psel = 0; penable = 0; pwrite = 0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
